// File: rtl/phase_mac_mc_if.sv
// Sample/config/result bus of the multi-channel phase MAC.
// slave  : seen by phase_mac_mc (takes s_*/cfg_*, drives m_*)
// master : seen by the sample source (drives s_*/cfg_*, takes m_*)
interface phase_mac_mc_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned TIME_W = 48,
    parameter int unsigned FREQ_W = 48,
    parameter int unsigned PH_W   = 14,
    parameter int unsigned ACC_W  = 48
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              s_valid;
    logic [CH_W-1:0]   s_ch;
    logic [TIME_W-1:0] s_timestamp;
    logic [TIME_W-1:0] s_time_offset;
    logic [FREQ_W-1:0] s_freq;
    logic [PH_W-1:0]   s_phase;
    logic              s_commit;

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_phase;

    logic              m_valid;
    logic [CH_W-1:0]   m_ch;
    logic [ACC_W-1:0]  m_phase;
    logic              m_commit;

    modport slave (
        input  s_valid, s_ch, s_timestamp, s_time_offset, s_freq, s_phase, s_commit,
        input  cfg_we, cfg_ch, cfg_phase,
        output m_valid, m_ch, m_phase, m_commit
    );

    modport master (
        output s_valid, s_ch, s_timestamp, s_time_offset, s_freq, s_phase, s_commit,
        output cfg_we, cfg_ch, cfg_phase,
        input  m_valid, m_ch, m_phase, m_commit
    );
endinterface

// File: rtl/phase_mac_mc.sv
// Multi-channel DDS phase multiply-accumulate, one sample per cycle, 4-cycle latency:
//   m_phase = (ts - offset) * freq + (phase << (ACC_W-PH_W)) + acc_phase[ch]  mod 2^ACC_W
// Ports: clk, resetn (async, active low), bus (phase_mac_mc_if.slave):
//   s_*   input sample stream, no backpressure
//   cfg_* per-channel accumulator write port
//   m_*   registered result stream
module phase_mac_mc #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned TIME_W = 48,
    parameter int unsigned FREQ_W = 48,
    parameter int unsigned PH_W   = 14,
    parameter int unsigned ACC_W  = 48
) (
    input  logic            clk,
    input  logic            resetn,
    phase_mac_mc_if.slave   bus
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SL_W  = 17;
    localparam int unsigned PP_W  = 2 * SL_W;
    localparam int unsigned NA    = (TIME_W + SL_W - 1) / SL_W;
    localparam int unsigned NB    = (FREQ_W + SL_W - 1) / SL_W;
    localparam int unsigned PAD_A = NA * SL_W;
    localparam int unsigned PAD_B = NB * SL_W;
    localparam int unsigned PH_SH = ACC_W - PH_W;

    // Channel indices beyond NUM_CH neither read nor write the accumulator bank.
    function automatic logic ch_ok(input logic [CH_W-1:0] ch);
        return {1'b0, ch} < (CH_W+1)'(NUM_CH);
    endfunction

    // S0: time difference
    logic              s0_valid_q, s0_valid_d;
    logic [CH_W-1:0]   s0_ch_q, s0_ch_d;
    logic [TIME_W-1:0] s0_diff_q, s0_diff_d;
    logic [FREQ_W-1:0] s0_freq_q, s0_freq_d;
    logic [PH_W-1:0]   s0_ph_q, s0_ph_d;
    logic              s0_commit_q, s0_commit_d;

    // S1: DSP-sized partial products and aligned phase offset
    logic              s1_valid_q, s1_valid_d;
    logic [CH_W-1:0]   s1_ch_q, s1_ch_d;
    logic              s1_commit_q, s1_commit_d;
    logic [PP_W-1:0]   s1_pp_q [NA][NB];
    logic [PP_W-1:0]   s1_pp_d [NA][NB];
    logic [ACC_W-1:0]  s1_phoff_q, s1_phoff_d;

    // S2a: per-row partial sums (first level of the summing tree)
    logic              s2a_valid_q, s2a_valid_d;
    logic [CH_W-1:0]   s2a_ch_q, s2a_ch_d;
    logic              s2a_commit_q, s2a_commit_d;
    logic [ACC_W-1:0]  s2a_row_q [NA];
    logic [ACC_W-1:0]  s2a_row_d [NA];
    logic [ACC_W-1:0]  s2a_phoff_q, s2a_phoff_d;

    // S2b: product + phase offset
    logic              s2b_valid_q, s2b_valid_d;
    logic [CH_W-1:0]   s2b_ch_q, s2b_ch_d;
    logic              s2b_commit_q, s2b_commit_d;
    logic [ACC_W-1:0]  s2b_sum_q, s2b_sum_d;

    // S3: output register and accumulator bank
    logic              m_valid_q, m_valid_d;
    logic [CH_W-1:0]   m_ch_q, m_ch_d;
    logic [ACC_W-1:0]  m_phase_q, m_phase_d;
    logic              m_commit_q, m_commit_d;
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];

    logic [PAD_A-1:0]  diff_pad;
    logic [PAD_B-1:0]  freq_pad;
    logic [ACC_W-1:0]  acc_eff;
    logic [ACC_W-1:0]  phase_new;
    logic              cfg_hit;

    // S0 capture; data held while idle
    always_comb begin
        s0_valid_d  = bus.s_valid;
        s0_ch_d     = s0_ch_q;
        s0_diff_d   = s0_diff_q;
        s0_freq_d   = s0_freq_q;
        s0_ph_d     = s0_ph_q;
        s0_commit_d = s0_commit_q;
        if (bus.s_valid) begin
            s0_ch_d     = bus.s_ch;
            s0_diff_d   = bus.s_timestamp - bus.s_time_offset;
            s0_freq_d   = bus.s_freq;
            s0_ph_d     = bus.s_phase;
            s0_commit_d = bus.s_commit;
        end
    end

    // S1: only partials whose weight lands below bit ACC_W are formed
    always_comb begin
        diff_pad    = PAD_A'(s0_diff_q);
        freq_pad    = PAD_B'(s0_freq_q);
        s1_valid_d  = s0_valid_q;
        s1_ch_d     = s0_ch_q;
        s1_commit_d = s0_commit_q;
        s1_phoff_d  = ACC_W'(s0_ph_q) << PH_SH;
        for (int unsigned i = 0; i < NA; i++) begin
            for (int unsigned j = 0; j < NB; j++) begin
                s1_pp_d[i][j] = '0;
                if (SL_W * (i + j) < ACC_W) begin
                    s1_pp_d[i][j] = PP_W'(diff_pad[i*SL_W +: SL_W]) *
                                    PP_W'(freq_pad[j*SL_W +: SL_W]);
                end
            end
        end
    end

    // S2a: weight and sum each row of partials
    always_comb begin
        s2a_valid_d  = s1_valid_q;
        s2a_ch_d     = s1_ch_q;
        s2a_commit_d = s1_commit_q;
        s2a_phoff_d  = s1_phoff_q;
        for (int unsigned i = 0; i < NA; i++) begin
            s2a_row_d[i] = '0;
            for (int unsigned j = 0; j < NB; j++) begin
                if (SL_W * (i + j) < ACC_W) begin
                    s2a_row_d[i] = s2a_row_d[i] +
                                   (ACC_W'(s1_pp_q[i][j]) << (SL_W * (i + j)));
                end
            end
        end
    end

    // S2b: fold rows and phase offset
    always_comb begin
        s2b_valid_d  = s2a_valid_q;
        s2b_ch_d     = s2a_ch_q;
        s2b_commit_d = s2a_commit_q;
        s2b_sum_d    = s2a_phoff_q;
        for (int unsigned i = 0; i < NA; i++) begin
            s2b_sum_d = s2b_sum_d + s2a_row_q[i];
        end
    end

    // S3: accumulator read with cfg forwarding, commit write-back (cfg wins)
    always_comb begin
        cfg_hit    = bus.cfg_we && ch_ok(bus.cfg_ch) && (bus.cfg_ch == s2b_ch_q);
        acc_eff    = '0;
        if (cfg_hit) begin
            acc_eff = bus.cfg_phase;
        end else if (ch_ok(s2b_ch_q)) begin
            acc_eff = acc_q[s2b_ch_q];
        end
        phase_new  = s2b_sum_q + acc_eff;

        m_valid_d  = s2b_valid_q;
        m_commit_d = s2b_valid_q & s2b_commit_q;
        m_ch_d     = m_ch_q;
        m_phase_d  = m_phase_q;
        if (s2b_valid_q) begin
            m_ch_d    = s2b_ch_q;
            m_phase_d = phase_new;
        end

        acc_d = acc_q;
        if (s2b_valid_q && s2b_commit_q && ch_ok(s2b_ch_q)) begin
            acc_d[s2b_ch_q] = phase_new;
        end
        if (bus.cfg_we && ch_ok(bus.cfg_ch)) begin
            acc_d[bus.cfg_ch] = bus.cfg_phase;
        end
    end

    // Pipeline and bank registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s0_valid_q   <= 1'b0;
            s0_ch_q      <= '0;
            s0_diff_q    <= '0;
            s0_freq_q    <= '0;
            s0_ph_q      <= '0;
            s0_commit_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_ch_q      <= '0;
            s1_commit_q  <= 1'b0;
            s1_phoff_q   <= '0;
            for (int unsigned i = 0; i < NA; i++) begin
                for (int unsigned j = 0; j < NB; j++) begin
                    s1_pp_q[i][j] <= '0;
                end
            end
            s2a_valid_q  <= 1'b0;
            s2a_ch_q     <= '0;
            s2a_commit_q <= 1'b0;
            s2a_phoff_q  <= '0;
            for (int unsigned i = 0; i < NA; i++) begin
                s2a_row_q[i] <= '0;
            end
            s2b_valid_q  <= 1'b0;
            s2b_ch_q     <= '0;
            s2b_commit_q <= 1'b0;
            s2b_sum_q    <= '0;
            m_valid_q    <= 1'b0;
            m_ch_q       <= '0;
            m_phase_q    <= '0;
            m_commit_q   <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            s0_valid_q   <= s0_valid_d;
            s0_ch_q      <= s0_ch_d;
            s0_diff_q    <= s0_diff_d;
            s0_freq_q    <= s0_freq_d;
            s0_ph_q      <= s0_ph_d;
            s0_commit_q  <= s0_commit_d;
            s1_valid_q   <= s1_valid_d;
            s1_ch_q      <= s1_ch_d;
            s1_commit_q  <= s1_commit_d;
            s1_phoff_q   <= s1_phoff_d;
            s1_pp_q      <= s1_pp_d;
            s2a_valid_q  <= s2a_valid_d;
            s2a_ch_q     <= s2a_ch_d;
            s2a_commit_q <= s2a_commit_d;
            s2a_phoff_q  <= s2a_phoff_d;
            s2a_row_q    <= s2a_row_d;
            s2b_valid_q  <= s2b_valid_d;
            s2b_ch_q     <= s2b_ch_d;
            s2b_commit_q <= s2b_commit_d;
            s2b_sum_q    <= s2b_sum_d;
            m_valid_q    <= m_valid_d;
            m_ch_q       <= m_ch_d;
            m_phase_q    <= m_phase_d;
            m_commit_q   <= m_commit_d;
            acc_q        <= acc_d;
        end
    end

    assign bus.m_valid  = m_valid_q;
    assign bus.m_ch     = m_ch_q;
    assign bus.m_phase  = m_phase_q;
    assign bus.m_commit = m_commit_q;
endmodule

// File: tb/tb_phase_mac_mc.sv
// Bench for phase_mac_mc: constant vector table, hand-built commit/cfg/reset
// sequences and a random interleaved stream against a behavioural model.
module tb_phase_mac_mc;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned TIME_W = 48;
    localparam int unsigned FREQ_W = 48;
    localparam int unsigned PH_W   = 14;
    localparam int unsigned ACC_W  = 48;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned LAT    = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    phase_mac_mc_if #(.NUM_CH(NUM_CH), .TIME_W(TIME_W), .FREQ_W(FREQ_W),
                      .PH_W(PH_W), .ACC_W(ACC_W)) bus ();

    phase_mac_mc #(.NUM_CH(NUM_CH), .TIME_W(TIME_W), .FREQ_W(FREQ_W),
                   .PH_W(PH_W), .ACC_W(ACC_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [ACC_W-1:0] phase;
        logic             commit;
        int               cyc;
    } exp_t;

    typedef struct {
        logic [TIME_W-1:0] ts;
        logic [TIME_W-1:0] off;
        logic [FREQ_W-1:0] freq;
        logic [PH_W-1:0]   ph;
        logic [CH_W-1:0]   ch;
        logic [ACC_W-1:0]  exp_phase;
    } vec_t;

    exp_t             sb[$];
    vec_t             vt[11];
    logic [ACC_W-1:0] acc_m [NUM_CH];
    int               n_vec = 0;
    int               n_err = 0;
    int               cyc = 0;

    always @(posedge clk) cyc++;

    // Output monitor: every m_valid pops one expectation, including its arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.m_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: m_valid=1 ch=%0d phase=%h at cycle %0d, required no output",
                         bus.m_ch, bus.m_phase, cyc);
            end else begin
                e = sb.pop_front();
                if (bus.m_ch !== e.ch || bus.m_phase !== e.phase ||
                    bus.m_commit !== e.commit || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL result: got ch=%0d phase=%h commit=%b cycle=%0d, required ch=%0d phase=%h commit=%b cycle=%0d",
                             bus.m_ch, bus.m_phase, bus.m_commit, cyc, e.ch, e.phase, e.commit, e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required termination");
        $fatal(1, "watchdog");
    end

    function automatic logic [ACC_W-1:0] model(input logic [TIME_W-1:0] ts,
                                               input logic [TIME_W-1:0] off,
                                               input logic [FREQ_W-1:0] freq,
                                               input logic [PH_W-1:0]   ph,
                                               input logic [ACC_W-1:0]  acc);
        logic [TIME_W-1:0]        d;
        logic [TIME_W+FREQ_W-1:0] p;
        d = ts - off;
        p = (TIME_W+FREQ_W)'(d) * (TIME_W+FREQ_W)'(freq);
        return p[ACC_W-1:0] + {ph, {(ACC_W-PH_W){1'b0}}} + acc;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.s_valid       = 1'b0;
        bus.s_ch          = '0;
        bus.s_timestamp   = '0;
        bus.s_time_offset = '0;
        bus.s_freq        = '0;
        bus.s_phase       = '0;
        bus.s_commit      = 1'b0;
        bus.cfg_we        = 1'b0;
        bus.cfg_ch        = '0;
        bus.cfg_phase     = '0;
    endtask

    // One accepted sample; the expectation is queued at drive time.
    task automatic send(input logic [CH_W-1:0] ch, input logic [TIME_W-1:0] ts,
                        input logic [TIME_W-1:0] off, input logic [FREQ_W-1:0] freq,
                        input logic [PH_W-1:0] ph, input logic commit,
                        input logic [ACC_W-1:0] exp_phase, input bit push);
        bus.s_valid       = 1'b1;
        bus.s_ch          = ch;
        bus.s_timestamp   = ts;
        bus.s_time_offset = off;
        bus.s_freq        = freq;
        bus.s_phase       = ph;
        bus.s_commit      = commit;
        if (push) sb.push_back('{ch, exp_phase, commit, cyc + 1 + LAT});
        step();
        bus.s_valid  = 1'b0;
        bus.s_commit = 1'b0;
    endtask

    // Sample whose expectation comes from the model; commits update the model bank.
    task automatic send_model(input logic [CH_W-1:0] ch, input logic [TIME_W-1:0] ts,
                              input logic [TIME_W-1:0] off, input logic [FREQ_W-1:0] freq,
                              input logic [PH_W-1:0] ph, input logic commit);
        logic [ACC_W-1:0] e;
        e = model(ts, off, freq, ph, acc_m[ch]);
        if (commit) acc_m[ch] = e;
        send(ch, ts, off, freq, ph, commit, e, 1'b1);
    endtask

    task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [ACC_W-1:0] val);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = ch;
        bus.cfg_phase = val;
        acc_m[ch]     = val;
        step();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_vec++;
        if (bus.m_valid !== 1'b0 || bus.m_ch !== '0 || bus.m_phase !== '0 || bus.m_commit !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got valid=%b ch=%0d phase=%h commit=%b, required all zero",
                     name, bus.m_valid, bus.m_ch, bus.m_phase, bus.m_commit);
        end
    endtask

    initial begin
        vt[0]  = '{48'd1000, 48'd400, 48'h0001_0000_0000, 14'd1, 2'd0, 48'h025C_0000_0000};
        vt[1]  = '{48'd0, 48'd1, 48'd1, 14'd0, 2'd0, 48'hFFFF_FFFF_FFFF};
        vt[2]  = '{48'd0, 48'd1, 48'd2, 14'd0, 2'd0, 48'hFFFF_FFFF_FFFE};
        vt[3]  = '{48'd0, 48'd0, 48'd0, 14'h3FFF, 2'd1, 48'hFFFC_0000_0000};
        vt[4]  = '{48'h1_0000, 48'd0, 48'h1_0000, 14'd0, 2'd2, 48'h0001_0000_0000};
        vt[5]  = '{48'h2_0000, 48'd0, 48'h2_0000, 14'd0, 2'd3, 48'h0004_0000_0000};
        vt[6]  = '{48'hFFFF_FFFF_FFFF, 48'd0, 48'hFFFF_FFFF_FFFF, 14'd0, 2'd0, 48'h0000_0000_0001};
        vt[7]  = '{48'd10, 48'd7, 48'd5, 14'd2, 2'd1, 48'h0008_0000_000F};
        vt[8]  = '{48'h4_0000_0000, 48'd0, 48'h2000, 14'd0, 2'd2, 48'h8000_0000_0000};
        vt[9]  = '{48'h6_0000, 48'd0, 48'h4_0000_0000, 14'd5, 2'd3, 48'h0014_0000_0000};
        vt[10] = '{48'd5, 48'd10, 48'd3, 14'd0, 2'd0, 48'hFFFF_FFFF_FFF1};
        for (int c = 0; c < int'(NUM_CH); c++) acc_m[c] = '0;

        idle_inputs();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_state");
        resetn = 1'b1;
        step();

        // Constant vectors, back to back, all accumulators zero.
        for (int i = 0; i < 11; i++) begin
            send(vt[i].ch, vt[i].ts, vt[i].off, vt[i].freq, vt[i].ph, 1'b0, vt[i].exp_phase, 1'b1);
        end
        wait_drain();
        // acc[0] untouched by non-committing samples.
        send(2'd0, 48'd5, 48'd5, 48'd0, 14'd0, 1'b0, 48'd0, 1'b1);
        wait_drain();

        // Back-to-back commits on ch2.
        cfg_write(2'd2, 48'h10);
        step();
        send(2'd2, 48'h100, 48'd0, 48'd1, 14'd0, 1'b1, 48'h110, 1'b1);
        send(2'd2, 48'h100, 48'd0, 48'd1, 14'd0, 1'b1, 48'h210, 1'b1);
        acc_m[2] = 48'h210;
        wait_drain();
        send(2'd2, 48'd9, 48'd9, 48'd3, 14'd0, 1'b0, 48'h210, 1'b1);
        wait_drain();

        // cfg write to ch1 on the edge a ch1 commit reaches the output.
        send(2'd1, 48'h20, 48'd0, 48'd1, 14'd0, 1'b1, 48'h25, 1'b1);
        send(2'd1, 48'h30, 48'd0, 48'd1, 14'd0, 1'b0, 48'h35, 1'b1);
        step();
        step();
        cfg_write(2'd1, 48'h5);
        wait_drain();
        send(2'd1, 48'd0, 48'd0, 48'd0, 14'd0, 1'b0, 48'h5, 1'b1);
        wait_drain();

        // Random interleaved stream with commits.
        for (int i = 0; i < 64; i++) begin
            send_model(CH_W'(i % int'(NUM_CH)), 48'({$urandom(), $urandom()}),
                       48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
                       14'($urandom()), 1'($urandom()));
        end
        wait_drain();

        // Reset with three samples in flight.
        send(2'd0, 48'd100, 48'd0, 48'd1, 14'd1, 1'b1, 48'd0, 1'b0);
        send(2'd1, 48'd200, 48'd0, 48'd1, 14'd2, 1'b1, 48'd0, 1'b0);
        send(2'd3, 48'd300, 48'd0, 48'd1, 14'd3, 1'b1, 48'd0, 1'b0);
        resetn = 1'b0;
        #1;
        check_outputs_zero("reset_async");
        for (int c = 0; c < int'(NUM_CH); c++) acc_m[c] = '0;
        repeat (3) step();
        resetn = 1'b1;
        repeat (10) step();
        send(2'd3, 48'd7, 48'd0, 48'd1, 14'd0, 1'b0, 48'd7, 1'b1);
        send_model(2'd0, 48'd0, 48'd0, 48'd0, 14'd0, 1'b0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
